// File: rtl/inst_sram_axi_rd_bridge.sv
// Instruction-fetch request port (req/addr_ok/data_ok) to AXI4 read bridge; in-order, flush-aware.
// Optional macro DUAL_FETCH_EN: 64-bit fetch via an 8-byte aligned two-beat INCR burst.
module inst_sram_axi_rd_bridge #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [3:0]  ARID_VAL = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  input  logic        inst_uncache_i,
  input  logic        inst_flush_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
`ifdef DUAL_FETCH_EN
  output logic [63:0] inst_rdata_o,
`else
  output logic [31:0] inst_rdata_o,
`endif
  output logic        inst_err_o,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic [3:0]  arcache_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

`ifdef DUAL_FETCH_EN
  localparam int unsigned RW = 64;
`else
  localparam int unsigned RW = 32;
`endif
  localparam int unsigned     CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic {AR_IDLE, AR_BUSY} ar_state_e;

  ar_state_e        state_q, state_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [3:0]       arcache_q, arcache_d;
  logic             arvalid_q, arvalid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cancel_q, cancel_d;
  logic             rready_q, rready_d;
  logic             data_ok_q, data_ok_d;
  logic [RW-1:0]    rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             err_acc_q, err_acc_d;
  logic [RW-1:0]    word;
  logic             err_beat;
  logic             accept, take, retire;
  logic             rid_unused;

  // Single ARID and in-order return, so the response ID carries no information.
  assign rid_unused = ^rid_i;

  assign accept   = (state_q == AR_IDLE) & inst_req_i & ~inst_flush_i & (cnt_q < DEPTH_C);
  assign take     = rvalid_i & rready_q & (cnt_q != '0);
  assign retire   = take & rlast_i;
  assign err_beat = err_acc_q | (rresp_i != 2'b00);

`ifdef DUAL_FETCH_EN
  logic        beat_q, beat_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    beat_d = beat_q;
    lo_d   = lo_q;
    if (take) begin
      beat_d = ~rlast_i;
      if (!beat_q) lo_d = rdata_i;
    end
  end

  assign word = {rdata_i, lo_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= 1'b0;
      lo_q   <= '0;
    end else begin
      beat_q <= beat_d;
      lo_q   <= lo_d;
    end
  end
`else
  assign word = rdata_i;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    araddr_d  = araddr_q;
    arcache_d = arcache_q;
    arvalid_d = arvalid_q;
    cnt_d     = cnt_q;
    cancel_d  = cancel_q;
    rready_d  = 1'b1;
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_acc_d = err_acc_q;

    case (state_q)
      AR_IDLE: begin
        if (accept) begin
`ifdef DUAL_FETCH_EN
          araddr_d = {inst_addr_i[31:3], 3'b000};
`else
          araddr_d = inst_addr_i;
`endif
          arcache_d = inst_uncache_i ? 4'b0000 : 4'b1111;
          arvalid_d = 1'b1;
          state_d   = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          state_d   = AR_IDLE;
        end
      end
      default: state_d = AR_IDLE;
    endcase

    if (accept && !retire)      cnt_d = cnt_q + ONE_C;
    else if (retire && !accept) cnt_d = cnt_q - ONE_C;

    if (take) err_acc_d = retire ? 1'b0 : err_beat;

    if (retire) begin
      if (cancel_q != '0) begin
        cancel_d = cancel_q - ONE_C;
      end else if (!inst_flush_i) begin
        data_ok_d = 1'b1;
        rdata_d   = word;
        err_d     = err_beat;
      end
    end

    // A flush supersedes the retire bookkeeping: everything still counted after this cycle is dead.
    if (inst_flush_i) cancel_d = cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= AR_IDLE;
      araddr_q  <= '0;
      arcache_q <= '0;
      arvalid_q <= 1'b0;
      cnt_q     <= '0;
      cancel_q  <= '0;
      rready_q  <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arcache_q <= arcache_d;
      arvalid_q <= arvalid_d;
      cnt_q     <= cnt_d;
      cancel_q  <= cancel_d;
      rready_q  <= rready_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_acc_q <= err_acc_d;
    end
  end

  assign inst_addr_ok_o = accept;
  assign inst_data_ok_o = data_ok_q;
  assign inst_rdata_o   = rdata_q;
  assign inst_err_o     = err_q;
  assign arid_o         = ARID_VAL;
  assign araddr_o       = araddr_q;
`ifdef DUAL_FETCH_EN
  assign arlen_o        = 8'd1;
`else
  assign arlen_o        = 8'd0;
`endif
  assign arsize_o       = 3'b010;
  assign arburst_o      = 2'b01;
  assign arcache_o      = arcache_q;
  assign arvalid_o      = arvalid_q;
  assign rready_o       = rready_q;

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Randomized bench: transaction-level fetch/AXI model feeds a scoreboard checked by a data_ok monitor.
module tb_inst_sram_axi_rd_bridge;
  localparam int DEPTH = 2;
`ifdef DUAL_FETCH_EN
  localparam int RW = 64;
  localparam int BEATS = 2;
`else
  localparam int RW = 32;
  localparam int BEATS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req_i, inst_uncache_i, inst_flush_i;
  logic [31:0]   inst_addr_i;
  logic          inst_addr_ok_o, inst_data_ok_o, inst_err_o;
  logic [RW-1:0] inst_rdata_o;
  logic [3:0]    arid_o, arcache_o;
  logic [31:0]   araddr_o;
  logic [7:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic [1:0]    arburst_o;
  logic          arvalid_o, arready_i;
  logic [3:0]    rid_i;
  logic [31:0]   rdata_i;
  logic [1:0]    rresp_i;
  logic          rlast_i, rvalid_i, rready_o;

  inst_sram_axi_rd_bridge #(.DEPTH(DEPTH), .ARID_VAL(4'd0)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_uncache_i(inst_uncache_i),
    .inst_flush_i(inst_flush_i), .inst_addr_ok_o(inst_addr_ok_o), .inst_data_ok_o(inst_data_ok_o),
    .inst_rdata_o(inst_rdata_o), .inst_err_o(inst_err_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arcache_o(arcache_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic unc; bit cancelled; } fetch_t;
  typedef struct { logic [RW-1:0] data; logic err; int due; } exp_t;

  fetch_t fq[$];          // accepted fetches not yet answered, oldest first
  exp_t   sb[$];          // responses the fetch stage must see
  int     ar_pend = 0;    // leading entries of fq whose AR has been handshaken
  int     total = 0, bad = 0, cyc = 0, n_acc = 0;

  logic        s_req = 0, s_unc = 0, s_flush = 0, s_arready = 1, s_rgo = 1, s_stray = 0;
  logic [31:0] s_addr = '0;
  logic [31:0] dq[$];
  logic [1:0]  rq[$];
  int          beat = 0;
  logic [RW-1:0] acc_data = '0;
  logic          acc_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus plus the reference model's view of what happens at the next edge.
  task automatic step();
    bit exp_ok, exp_arv, stray;
    logic [31:0] exp_addr;
    fetch_t f;
    @(negedge clk);
    cyc++;
    inst_req_i = s_req; inst_addr_i = s_addr; inst_uncache_i = s_unc;
    inst_flush_i = s_flush; arready_i = s_arready;
    rvalid_i = 1'b0; rlast_i = 1'b0; rdata_i = '0; rresp_i = '0; rid_i = '0;
    stray = s_stray && fq.size() == 0 && ar_pend == 0;
    if (stray) begin
      rvalid_i = 1'b1; rlast_i = 1'b1; rdata_i = 32'hDEADBEEF;
    end else if (s_rgo && ar_pend > 0) begin
      rvalid_i = 1'b1;
      rlast_i  = (beat == BEATS - 1);
      rdata_i  = (dq.size() != 0) ? dq.pop_front() : $urandom();
      rresp_i  = (rq.size() != 0) ? rq.pop_front() : (($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00);
    end
    #1;
    exp_arv = ar_pend < fq.size();
    exp_ok  = s_req && !s_flush && fq.size() < DEPTH && !exp_arv;
    check("rready", rready_o, 1);
    check("addr_ok", inst_addr_ok_o, exp_ok);
    check("arvalid", arvalid_o, exp_arv);
    if (exp_arv) begin
      exp_addr = fq[ar_pend].addr;
      if (BEATS == 2) exp_addr[2:0] = 3'b000;
      check("araddr", araddr_o, exp_addr);
      check("arcache", arcache_o, fq[ar_pend].unc ? 4'h0 : 4'hF);
      check("ar_fixed", {arid_o, arlen_o, arsize_o, arburst_o}, {4'd0, 8'(BEATS - 1), 3'b010, 2'b01});
      if (arready_i) ar_pend++;
    end
    if (rvalid_i && !stray) begin
      acc_data[beat*32 +: 32] = rdata_i;
      acc_err = acc_err | (rresp_i != 2'b00);
      if (rlast_i) begin
        f = fq.pop_front();
        ar_pend--;
        if (!f.cancelled && !s_flush) sb.push_back('{acc_data, acc_err, cyc + 1});
        beat = 0; acc_data = '0; acc_err = 1'b0;
      end else begin
        beat++;
      end
    end
    if (exp_ok) begin
      fq.push_back('{inst_addr_i, inst_uncache_i, 1'b0});
      n_acc++;
    end
    if (s_flush) foreach (fq[i]) fq[i].cancelled = 1'b1;
  endtask

  task automatic idle(input int n);
    s_req = 0; s_flush = 0;
    repeat (n) step();
  endtask

  task automatic fetch_one(input logic [31:0] a, input logic u);
    int n0 = n_acc;
    s_req = 1; s_addr = a; s_unc = u;
    for (int i = 0; i < 50 && n_acc == n0; i++) step();
    s_req = 0;
    check("fetch_accepted", 64'(n_acc - n0), 1);
  endtask

  // Monitor: runs after the driver has advanced cyc for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (inst_data_ok_o === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_data_ok: got rdata %h, no response outstanding (cycle %0d)", inst_rdata_o, cyc);
        end else begin
          e = sb.pop_front();
          check("rdata", inst_rdata_o, e.data);
          check("err", inst_err_o, e.err);
          check("latency", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() != 0 && sb[0].due < cyc) begin
        total++; bad++;
        $display("FAIL missing_data_ok: got none, expected rdata %h at cycle %0d", sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1;
    inst_req_i = 0; inst_addr_i = '0; inst_uncache_i = 0; inst_flush_i = 0;
    arready_i = 0; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 0; rvalid_i = 0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {inst_addr_ok_o, inst_data_ok_o, inst_err_o, arvalid_o, rready_o}, 5'b0);
    check("rst_rdata", inst_rdata_o, 0);
    rst = 1'b0;

    // Single cached fetch.
    dq.push_back(32'h02800C00); if (BEATS == 2) dq.push_back(32'h12345678);
    rq.push_back(2'b00);        if (BEATS == 2) rq.push_back(2'b00);
    fetch_one(32'h1C000000, 1'b0);
    idle(6);

    // Outstanding limit with R stalled, then in-order return.
    s_rgo = 0; s_req = 1; s_addr = 32'h1C000010; n0 = n_acc;
    repeat (8) step();
    check("limit_accepts", 64'(n_acc - n0), 2);
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < BEATS; b++) begin
        dq.push_back(k == 0 ? 32'h11111111 : 32'h22222222);
        rq.push_back(2'b00);
      end
    s_rgo = 1;
    for (int i = 0; i < 20 && n_acc - n0 < 3; i++) step();
    check("third_accept", 64'(n_acc - n0), 3);
    idle(10);

    // Flush with two outstanding, second AR held in BUSY by a late arready.
    s_rgo = 0; s_arready = 1; s_req = 1; s_addr = 32'h1C000040; n0 = n_acc;
    for (int i = 0; i < 20 && n_acc - n0 < 2; i++) step();
    s_req = 0; s_arready = 0;
    step();
    s_flush = 1; step(); s_flush = 0;
    step(); step();
    s_arready = 1; s_rgo = 1;
    idle(10);
    fetch_one(32'h1C000100, 1'b0);
    idle(8);

    // Flush in the same cycle as the last beat of the only outstanding read.
    s_rgo = 0;
    fetch_one(32'h1C000200, 1'b0);
    idle(3);
    s_rgo = 1;
    repeat (BEATS - 1) step();
    s_flush = 1; step(); s_flush = 0;
    idle(3);
    fetch_one(32'h1C000204, 1'b0);
    idle(8);

    // Uncached fetch with an error response.
    rq.push_back(2'b10); if (BEATS == 2) rq.push_back(2'b00);
    fetch_one(32'h1FC00000, 1'b1);
    idle(8);

`ifdef DUAL_FETCH_EN
    dq.push_back(32'hAAAA0000); dq.push_back(32'hBBBB1111);
    rq.push_back(2'b00); rq.push_back(2'b00);
    fetch_one(32'h1C000004, 1'b0);
    idle(8);
`endif

    // Stray response with nothing outstanding must be ignored.
    s_stray = 1; step(); s_stray = 0;
    idle(4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s_req     = ($urandom_range(0, 9) < 6);
      s_flush   = ($urandom_range(0, 24) == 0);
      s_arready = ($urandom_range(0, 1) == 1);
      s_rgo     = ($urandom_range(0, 2) != 0);
      s_unc     = ($urandom_range(0, 3) == 0);
      s_addr    = $urandom() & 32'hFFFF_FFFC;
      step();
    end
    s_arready = 1; s_rgo = 1;
    idle(30);
    check("scoreboard_drained", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
